bcd_countdown_timer: RTL and testbench

//   Parametrised multi-decade BCD down-counter/timer with synchronous preset,

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit.sv | 41 ++++
 rtl/bcd_countdown_timer.sv | 88 ++++++++
 tb/tb_bcd_countdown_timer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - BCD nibble constants and helpers shared by the countdown timer
package bcd_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic bcd_is_valid(input logic [BCD_W-1:0] nibble);
    return nibble <= BCD_MAX;
  endfunction

  // Out-of-range nibbles saturate to 9 so a digit register never holds A..F.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
    return bcd_is_valid(nibble) ? nibble : BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade register with preset, reload and borrow-out
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clock,
  input  logic             clrn,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  input  logic             dec,
  input  logic             rld,
  input  logic [BCD_W-1:0] rld_val,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (rld) begin
      q_d = rld_val;
    end else if (dec) begin
      q_d = (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign q          = q_q;
  assign borrow_out = dec & (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-decade BCD down-counter with one-shot/auto-reload modes
module bcd_countdown_timer
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2
) (
  input  logic                          clock,
  input  logic                          clrn,
  input  logic                          loadn,
  input  logic                          enable,
  input  logic                          reload,
  input  logic [BCD_W*NUM_DIGITS-1:0]   data,
  output logic [BCD_W*NUM_DIGITS-1:0]   count,
  output logic                          tc,
  output logic                          zero,
  output logic                          err
);

  localparam int W = BCD_W * NUM_DIGITS;

  logic [W-1:0]        data_clamped;
  logic                bad_nibble;
  logic [W-1:0]        reload_val_q, reload_val_d;
  logic                tc_q, tc_d;
  logic                err_q, err_d;
  logic                load, step, is_zero, is_one, rld_en;
  logic [NUM_DIGITS:0] dec_chain;
  logic                borrow_unused;

  always_comb begin
    data_clamped = '0;
    bad_nibble   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      data_clamped[i*BCD_W +: BCD_W] = bcd_clamp(data[i*BCD_W +: BCD_W]);
      bad_nibble = bad_nibble | ~bcd_is_valid(data[i*BCD_W +: BCD_W]);
    end
  end

  assign load    = ~loadn;
  assign step    = loadn & enable;
  assign is_zero = (count == '0);
  assign is_one  = (count == W'(1));

  // In auto-reload mode both the 1->terminal step and an idle zero reload the preset;
  // with a zero preset that simply reloads 0, which is the required hold.
  assign rld_en       = step & reload & (is_one | is_zero);
  assign dec_chain[0] = step & ~is_zero & ~rld_en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clock      (clock),
      .clrn       (clrn),
      .ld         (load),
      .ld_val     (data_clamped[g*BCD_W +: BCD_W]),
      .dec        (dec_chain[g]),
      .rld        (rld_en),
      .rld_val    (reload_val_q[g*BCD_W +: BCD_W]),
      .q          (count[g*BCD_W +: BCD_W]),
      .borrow_out (dec_chain[g+1])
    );
  end

  // Borrow out of the top decade cannot occur: digit 0 is never decremented at zero.
  assign borrow_unused = dec_chain[NUM_DIGITS];

  always_comb begin
    reload_val_d = load ? data_clamped : reload_val_q;
    err_d        = load ? bad_nibble : err_q;
    tc_d         = step & is_one;
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      reload_val_q <= '0;
      tc_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      reload_val_q <= reload_val_d;
      tc_q         <= tc_d;
      err_q        <= err_d;
    end
  end

  assign tc   = tc_q;
  assign err  = err_q;
  assign zero = is_zero;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - vector table and scoreboard bench for bcd_countdown_timer
module tb_bcd_countdown_timer;

  typedef struct {
    bit          wide;
    logic        loadn;
    logic        enable;
    logic        reload;
    logic [11:0] data;
    logic [11:0] exp_count;
    logic        exp_tc;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [11:0] cnt;
    logic        tc;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clock = 1'b0;
  logic        clrn  = 1'b0;
  logic        loadn2 = 1'b1, en2 = 1'b0, rld2 = 1'b0;
  logic [7:0]  data2 = 8'h00;
  logic [7:0]  count2;
  logic        tc2, zero2, err2;
  logic        loadn3 = 1'b1, en3 = 1'b0, rld3 = 1'b0;
  logic [11:0] data3 = 12'h000;
  logic [11:0] count3;
  logic        tc3, zero3, err3;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clock = ~clock;

  bcd_countdown_timer #(.NUM_DIGITS(2)) dut2 (
    .clock(clock), .clrn(clrn), .loadn(loadn2), .enable(en2), .reload(rld2),
    .data(data2), .count(count2), .tc(tc2), .zero(zero2), .err(err2)
  );

  bcd_countdown_timer #(.NUM_DIGITS(3)) dut3 (
    .clock(clock), .clrn(clrn), .loadn(loadn3), .enable(en3), .reload(rld3),
    .data(data3), .count(count3), .tc(tc3), .zero(zero3), .err(err3)
  );

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic add(input bit w, input logic l, input logic e, input logic r,
                     input logic [11:0] d, input logic [11:0] c,
                     input logic t, input logic z, input logic er);
    vec_t v;
    v = '{wide: w, loadn: l, enable: e, reload: r, data: d,
          exp_count: c, exp_tc: t, exp_zero: z, exp_err: er};
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t got;
    @(negedge clock);
    if (v.wide) begin
      loadn3 = v.loadn; en3 = v.enable; rld3 = v.reload; data3 = v.data;
    end else begin
      loadn2 = v.loadn; en2 = v.enable; rld2 = v.reload; data2 = v.data[7:0];
    end
    sb.push_back('{cnt: v.exp_count, tc: v.exp_tc, zero: v.exp_zero, err: v.exp_err});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    if (v.wide) got = '{cnt: count3, tc: tc3, zero: zero3, err: err3};
    else        got = '{cnt: {4'h0, count2}, tc: tc2, zero: zero2, err: err2};
    chk($sformatf("vec%0d count", idx), got.cnt, e.cnt);
    chk($sformatf("vec%0d tc", idx), {11'd0, got.tc}, {11'd0, e.tc});
    chk($sformatf("vec%0d zero", idx), {11'd0, got.zero}, {11'd0, e.zero});
    chk($sformatf("vec%0d err", idx), {11'd0, got.err}, {11'd0, e.err});
    loadn2 = 1'b1; en2 = 1'b0; loadn3 = 1'b1; en3 = 1'b0;
  endtask

  initial begin
    // One-shot countdown from 12, then hold at zero.
    add(0, 0, 0, 0, 12'h012, 12'h012, 0, 0, 0);
    for (int i = 0; i < 12; i++) add(0, 1, 1, 0, 12'h0, to_bcd(11 - i), (i == 11), (i == 11), 0);
    for (int i = 0; i < 2; i++)  add(0, 1, 1, 0, 12'h0, 12'h000, 0, 1, 0);
    // Auto-reload with period 5.
    add(0, 0, 0, 1, 12'h005, 12'h005, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      int v;
      v = 4 - (i % 5);
      add(0, 1, 1, 1, 12'h0, to_bcd(v == 0 ? 5 : v), (v == 0), 0, 0);
    end
    // Load beats the terminal step.
    add(0, 0, 0, 0, 12'h002, 12'h002, 0, 0, 0);
    add(0, 1, 1, 0, 12'h0, 12'h001, 0, 0, 0);
    add(0, 0, 1, 0, 12'h047, 12'h047, 0, 0, 0);
    // One-shot to zero, then switch to auto-reload from zero, then idle.
    add(0, 0, 0, 0, 12'h003, 12'h003, 0, 0, 0);
    add(0, 1, 1, 0, 12'h0, 12'h002, 0, 0, 0);
    add(0, 1, 1, 0, 12'h0, 12'h001, 0, 0, 0);
    add(0, 1, 1, 0, 12'h0, 12'h000, 1, 1, 0);
    add(0, 1, 1, 0, 12'h0, 12'h000, 0, 1, 0);
    add(0, 1, 1, 1, 12'h0, 12'h003, 0, 0, 0);
    add(0, 1, 1, 1, 12'h0, 12'h002, 0, 0, 0);
    add(0, 1, 0, 1, 12'h0, 12'h002, 0, 0, 0);
    // Auto-reload with a zero preset holds at zero.
    add(0, 0, 0, 1, 12'h000, 12'h000, 0, 1, 0);
    add(0, 1, 1, 1, 12'h0, 12'h000, 0, 1, 0);
    // Invalid nibble clamping and err tracking.
    add(0, 0, 0, 0, 12'h03A, 12'h039, 0, 0, 1);
    add(0, 0, 0, 0, 12'h020, 12'h020, 0, 0, 0);
    add(0, 0, 0, 0, 12'h0F5, 12'h095, 0, 0, 1);
    add(0, 1, 0, 0, 12'h0, 12'h095, 0, 0, 1);
    add(0, 0, 0, 0, 12'h03A, 12'h039, 0, 0, 1);
    add(0, 1, 1, 0, 12'h0, 12'h038, 0, 0, 1);
    add(0, 1, 1, 0, 12'h0, 12'h037, 0, 0, 1);
    // Three decades: borrow across two digits.
    add(1, 0, 0, 0, 12'h100, 12'h100, 0, 0, 0);
    add(1, 1, 1, 0, 12'h0, 12'h099, 0, 0, 0);
    add(1, 1, 1, 0, 12'h0, 12'h098, 0, 0, 0);
    add(1, 0, 0, 0, 12'h9A0, 12'h990, 0, 0, 1);
    add(1, 0, 0, 0, 12'h001, 12'h001, 0, 0, 0);
    add(1, 1, 1, 0, 12'h0, 12'h000, 1, 1, 0);

    #12;
    chk("reset count2", {4'h0, count2}, 12'h000);
    chk("reset zero2", {11'd0, zero2}, 12'd1);
    chk("reset tc2", {11'd0, tc2}, 12'd0);
    chk("reset err2", {11'd0, err2}, 12'd0);
    chk("reset count3", count3, 12'h000);
    @(negedge clock);
    clrn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Asynchronous reset mid-count: dut2 at 37 with err set, dut3 showing tc.
    #2;
    clrn = 1'b0;
    #1;
    chk("async count2", {4'h0, count2}, 12'h000);
    chk("async tc2", {11'd0, tc2}, 12'd0);
    chk("async err2", {11'd0, err2}, 12'd0);
    chk("async zero2", {11'd0, zero2}, 12'd1);
    chk("async tc3", {11'd0, tc3}, 12'd0);
    chk("async count3", count3, 12'h000);
    @(negedge clock);
    clrn = 1'b1;
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
